// File: rtl/membus_arbiter_if.sv
// Memory bus port bundle (req/valid protocol) shared by masters, slaves and
// the arbiter. The master side issues requests; the slave side answers them.
interface membus_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        valid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  valid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output valid, rdata
  );
endinterface

// File: rtl/membus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the memory bus.
// Each grant covers exactly one transaction. A watchdog completes any
// transaction the slave does not answer within TIMEOUT_CYCLES busy cycles,
// returning TIMEOUT_RDATA and latching a sticky error.
module membus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             res,
  membus_arbiter_if.slave  m0,
  membus_arbiter_if.slave  m1,
  membus_arbiter_if.master s,
  output logic [1:0]       grant,
  output logic             err,
  output logic             err_master,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } state_t;

  // A zero TIMEOUT_CYCLES disables the watchdog; the counter keeps a
  // one-bit minimum width so the declaration stays legal in that case.
  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    WD_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             last_grant_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_s;
  logic             timeout_s;
  logic             err_r;
  logic             err_master_r;

  assign err        = err_r;
  assign err_master = err_master_r;

  // Decode whether a transaction is in flight (illegal encodings count as idle).
  always_comb begin
    if ((state_r == BUSY_M0) || (state_r == BUSY_M1)) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // Watchdog fires on the last allowed busy cycle unless the slave answers in it.
  always_comb begin
    if (WD_EN && busy_s && !s.valid && (cnt_r == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: round-robin on ties, release on slave answer or timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (m0.req && m1.req) begin
          state_nxt_s = last_grant_r ? BUSY_M0 : BUSY_M1;
        end else if (m0.req) begin
          state_nxt_s = BUSY_M0;
        end else if (m1.req) begin
          state_nxt_s = BUSY_M1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY_M0, BUSY_M1: begin
        if (s.valid || timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: slave-side mux and master-side return path for the owner.
  always_comb begin
    s.req    = 1'b0;
    s.we     = 1'b0;
    s.be     = 4'b0000;
    s.addr   = 32'h0000_0000;
    s.wdata  = 32'h0000_0000;
    m0.valid = 1'b0;
    m0.rdata = 32'h0000_0000;
    m1.valid = 1'b0;
    m1.rdata = 32'h0000_0000;
    grant    = 2'b00;
    case (state_r)
      IDLE: begin
        grant = 2'b00;
      end
      BUSY_M0: begin
        grant    = 2'b01;
        s.req    = 1'b1;
        s.we     = m0.we;
        s.be     = m0.be;
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        m0.valid = s.valid | timeout_s;
        m0.rdata = timeout_s ? TIMEOUT_RDATA : s.rdata;
      end
      BUSY_M1: begin
        grant    = 2'b10;
        s.req    = 1'b1;
        s.we     = m1.we;
        s.be     = m1.be;
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        m1.valid = s.valid | timeout_s;
        m1.rdata = timeout_s ? TIMEOUT_RDATA : s.rdata;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  // Remember the most recent owner; reset favours M0 on the first tie.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      last_grant_r <= 1'b1;
    end else if ((state_r == IDLE) && (state_nxt_s == BUSY_M0)) begin
      last_grant_r <= 1'b0;
    end else if ((state_r == IDLE) && (state_nxt_s == BUSY_M1)) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Watchdog counter: counts unanswered busy cycles, zero whenever idle.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (WD_EN && busy_s && !s.valid && !timeout_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Sticky error: a new timeout takes priority over a simultaneous clear.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      err_r        <= 1'b0;
      err_master_r <= 1'b0;
    end else if (timeout_s) begin
      err_r        <= 1'b1;
      err_master_r <= (state_r == BUSY_M1);
    end else if (err_clr) begin
      err_r        <= 1'b0;
      err_master_r <= err_master_r;
    end else begin
      err_r        <= err_r;
      err_master_r <= err_master_r;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed testbench for membus_arbiter with a 4-cycle watchdog.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 3 time units after it, well clear of the next edge.
module tb_membus_arbiter;

  logic clk;
  logic res;
  logic err_clr;
  logic [1:0] grant;
  logic err;
  logic err_master;

  int errors;
  int checks;

  membus_arbiter_if m0_if ();
  membus_arbiter_if m1_if ();
  membus_arbiter_if s_if ();

  membus_arbiter #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_RDATA  (32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .res        (res),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .grant      (grant),
    .err        (err),
    .err_master (err_master),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_time_limit: got still running want finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.be = 4'h0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.be = 4'h0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
    s_if.valid = 1'b0;
    s_if.rdata = 32'h0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    res = 1'b1;
    tick();
    res = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0;
    idle_inputs();
    s_if.rdata = 32'h5555_AAAA;
    s_if.valid = 1'b1;
    #1 res = 1'b1;
    tick();
    tick();
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
    checks++; if (s_if.req !== 1'b0) begin errors++; $display("FAIL rst_sreq: got %b want 0", s_if.req); end
    checks++; if ({m1_if.valid, m0_if.valid} !== 2'b00) begin errors++; $display("FAIL rst_valid: got %b want 00", {m1_if.valid, m0_if.valid}); end
    checks++; if ({m0_if.rdata, m1_if.rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {m0_if.rdata, m1_if.rdata}); end
    checks++; if ({err, err_master} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", {err, err_master}); end
    s_if.valid = 1'b0;
    s_if.rdata = 32'h0;
    res = 1'b0;
  endtask

  task automatic test_single_read();
    // cycle 0: request appears
    tick();
    m0_if.req = 1'b1; m0_if.addr = 32'h0000_0100; m0_if.be = 4'hF; m0_if.we = 1'b0;
    #2;
    checks++; if (s_if.req !== 1'b0) begin errors++; $display("FAIL rd_c0_sreq: got %b want 0", s_if.req); end
    // cycle 1
    tick(); #2;
    checks++; if (s_if.req !== 1'b1) begin errors++; $display("FAIL rd_c1_sreq: got %b want 1", s_if.req); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_c1_grant: got %b want 01", grant); end
    checks++; if (s_if.addr !== 32'h0000_0100) begin errors++; $display("FAIL rd_c1_addr: got %h want 00000100", s_if.addr); end
    // cycle 2
    tick(); #2;
    checks++; if (s_if.req !== 1'b1) begin errors++; $display("FAIL rd_c2_sreq: got %b want 1", s_if.req); end
    checks++; if (m0_if.valid !== 1'b0) begin errors++; $display("FAIL rd_c2_m0valid: got %b want 0", m0_if.valid); end
    // cycle 3: slave answers
    tick();
    s_if.valid = 1'b1; s_if.rdata = 32'h1234_5678;
    #2;
    checks++; if (m0_if.valid !== 1'b1) begin errors++; $display("FAIL rd_c3_m0valid: got %b want 1", m0_if.valid); end
    checks++; if (m0_if.rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_c3_rdata: got %h want 12345678", m0_if.rdata); end
    checks++; if (m1_if.valid !== 1'b0) begin errors++; $display("FAIL rd_c3_m1valid: got %b want 0", m1_if.valid); end
    checks++; if (s_if.req !== 1'b1) begin errors++; $display("FAIL rd_c3_sreq: got %b want 1", s_if.req); end
    // cycle 4: released
    tick();
    s_if.valid = 1'b0; s_if.rdata = 32'h0; m0_if.req = 1'b0;
    #2;
    checks++; if (s_if.req !== 1'b0) begin errors++; $display("FAIL rd_c4_sreq: got %b want 0", s_if.req); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_c4_grant: got %b want 00", grant); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick();
    m0_if.req = 1'b1; m0_if.addr = 32'h0000_0010;
    m1_if.req = 1'b1; m1_if.addr = 32'h0000_0020;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL b2b_c0_grant: got %b want 00", grant); end
    for (int g = 0; g < 4; g++) begin
      logic [1:0]  exp_g;
      logic [31:0] exp_addr;
      logic [31:0] own_rdata;
      logic [31:0] oth_rdata;
      exp_g    = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (g % 2 == 0) ? 32'h0000_0010 : 32'h0000_0020;
      tick(); #2;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL b2b_grant%0d: got %b want %b", g, grant, exp_g); end
      checks++; if (s_if.addr !== exp_addr) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", g, s_if.addr, exp_addr); end
      tick();
      s_if.valid = 1'b1; s_if.rdata = 32'h1000_0000 + 32'(g);
      #2;
      own_rdata = (g % 2 == 0) ? m0_if.rdata : m1_if.rdata;
      oth_rdata = (g % 2 == 0) ? m1_if.rdata : m0_if.rdata;
      checks++; if ({m1_if.valid, m0_if.valid} !== exp_g) begin errors++; $display("FAIL b2b_valid%0d: got %b want %b", g, {m1_if.valid, m0_if.valid}, exp_g); end
      checks++; if (own_rdata !== 32'h1000_0000 + 32'(g)) begin errors++; $display("FAIL b2b_rdata%0d: got %h want %h", g, own_rdata, 32'h1000_0000 + 32'(g)); end
      checks++; if (oth_rdata !== 32'h0) begin errors++; $display("FAIL b2b_other_rdata%0d: got %h want 0", g, oth_rdata); end
      tick();
      s_if.valid = 1'b0; s_if.rdata = 32'h0;
      if (g == 3) begin
        m0_if.req = 1'b0; m1_if.req = 1'b0;
      end
      #2;
      checks++; if ({grant, s_if.req} !== 3'b000) begin errors++; $display("FAIL b2b_gap%0d: got %b want 000", g, {grant, s_if.req}); end
    end
    tick(); #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL b2b_end_grant: got %b want 00", grant); end
  endtask

  task automatic test_write_mux();
    tick();
    m0_if.we = 1'b0; m0_if.be = 4'hF; m0_if.addr = 32'h1111_1111; m0_if.wdata = 32'h2222_2222;
    m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.be = 4'b0011;
    m1_if.addr = 32'h8000_0004; m1_if.wdata = 32'hCAFE_F00D;
    tick(); #2;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b want 10", grant); end
    checks++; if ({s_if.req, s_if.we, s_if.be} !== 6'b110011) begin errors++; $display("FAIL wr_ctl: got %b want 110011", {s_if.req, s_if.we, s_if.be}); end
    checks++; if (s_if.addr !== 32'h8000_0004) begin errors++; $display("FAIL wr_addr: got %h want 80000004", s_if.addr); end
    checks++; if (s_if.wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_wdata: got %h want cafef00d", s_if.wdata); end
    tick();
    s_if.valid = 1'b1; s_if.rdata = 32'h0BAD_0001;
    #2;
    checks++; if ({m1_if.valid, m0_if.valid} !== 2'b10) begin errors++; $display("FAIL wr_valid: got %b want 10", {m1_if.valid, m0_if.valid}); end
    checks++; if (m0_if.rdata !== 32'h0) begin errors++; $display("FAIL wr_m0_rdata: got %h want 0", m0_if.rdata); end
    tick();
    s_if.valid = 1'b0; s_if.rdata = 32'h0; m1_if.req = 1'b0;
    #2;
    checks++; if ({s_if.req, s_if.we, s_if.be, s_if.addr, s_if.wdata} !== 70'h0) begin errors++; $display("FAIL wr_idle_bus: got %h want 0", {s_if.req, s_if.we, s_if.be, s_if.addr, s_if.wdata}); end
  endtask

  task automatic test_timeout();
    tick();
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 32'h0000_0200;
    for (int c = 1; c <= 3; c++) begin
      tick(); #2;
      checks++; if (m0_if.valid !== 1'b0) begin errors++; $display("FAIL to_early_valid_c%0d: got %b want 0", c, m0_if.valid); end
    end
    tick(); #2;
    checks++; if (m0_if.valid !== 1'b1) begin errors++; $display("FAIL to_valid: got %b want 1", m0_if.valid); end
    checks++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata: got %h want deadbeef", m0_if.rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b want 0", err); end
    tick();
    m0_if.req = 1'b0; err_clr = 1'b1;
    #2;
    checks++; if ({err, err_master} !== 2'b10) begin errors++; $display("FAIL to_err_set: got %b want 10", {err, err_master}); end
    checks++; if (s_if.req !== 1'b0) begin errors++; $display("FAIL to_sreq: got %b want 0", s_if.req); end
    tick();
    err_clr = 1'b0;
    #2;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b want 0", err); end
  endtask

  task automatic test_timeout_race();
    tick();
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 32'h0000_0300;
    repeat (3) tick();
    tick();
    s_if.valid = 1'b1; s_if.rdata = 32'hABCD_0123;
    #2;
    checks++; if ({m1_if.valid, m0_if.valid} !== 2'b10) begin errors++; $display("FAIL race_valid: got %b want 10", {m1_if.valid, m0_if.valid}); end
    checks++; if (m1_if.rdata !== 32'hABCD_0123) begin errors++; $display("FAIL race_rdata: got %h want abcd0123", m1_if.rdata); end
    tick();
    s_if.valid = 1'b0; s_if.rdata = 32'h0; m1_if.req = 1'b0;
    #2;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL race_err: got %b want 0", err); end
  endtask

  task automatic test_timeout_clr_race();
    tick();
    m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'h0000_0400;
    repeat (3) tick();
    tick();
    err_clr = 1'b1;
    #2;
    checks++; if (m1_if.valid !== 1'b1) begin errors++; $display("FAIL wto_valid: got %b want 1", m1_if.valid); end
    checks++; if (m1_if.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wto_rdata: got %h want deadbeef", m1_if.rdata); end
    tick();
    err_clr = 1'b0; m1_if.req = 1'b0;
    #2;
    checks++; if ({err, err_master} !== 2'b11) begin errors++; $display("FAIL wto_err: got %b want 11", {err, err_master}); end
  endtask

  task automatic test_reset_mid();
    tick();
    m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'h0000_3000;
    tick(); #2;
    checks++; if ({grant, s_if.req} !== 3'b101) begin errors++; $display("FAIL rm_busy: got %b want 101", {grant, s_if.req}); end
    tick();
    res = 1'b1; s_if.valid = 1'b1; s_if.rdata = 32'h0000_0077;
    #2;
    checks++; if ({grant, s_if.req, s_if.we, s_if.addr} !== 36'h0) begin errors++; $display("FAIL rm_outputs: got %h want 0", {grant, s_if.req, s_if.we, s_if.addr}); end
    checks++; if ({m1_if.valid, m0_if.valid, m1_if.rdata} !== 34'h0) begin errors++; $display("FAIL rm_master_side: got %h want 0", {m1_if.valid, m0_if.valid, m1_if.rdata}); end
    checks++; if ({err, err_master} !== 2'b00) begin errors++; $display("FAIL rm_err: got %b want 00", {err, err_master}); end
    tick();
    res = 1'b0; m1_if.req = 1'b0; s_if.valid = 1'b0;
    tick();
    s_if.valid = 1'b1;
    #2;
    checks++; if ({grant, m1_if.valid, m0_if.valid} !== 4'b0000) begin errors++; $display("FAIL rm_stray: got %b want 0000", {grant, m1_if.valid, m0_if.valid}); end
    tick();
    s_if.valid = 1'b0; m0_if.req = 1'b1; m1_if.req = 1'b1;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_tie_idle: got %b want 00", grant); end
    tick();
    s_if.valid = 1'b1; s_if.rdata = 32'h0000_0042;
    #2;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_tie_grant: got %b want 01", grant); end
    checks++; if ({m1_if.valid, m0_if.valid} !== 2'b01) begin errors++; $display("FAIL rm_tie_valid: got %b want 01", {m1_if.valid, m0_if.valid}); end
    tick();
    s_if.valid = 1'b0; m0_if.req = 1'b0; m1_if.req = 1'b0;
    #2;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_end: got %b want 00", grant); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_mux();
    test_timeout();
    test_timeout_race();
    test_timeout_clr_race();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
